// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler: registered one-hot grant for a single shared resource,
// released by done, requester withdrawal, or a hold-limit timeout.
module rr_grant_scheduler #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_HOLD = 8,
  localparam int unsigned IDW     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             done,
  output logic [WIDTH-1:0] grant,
  output logic [IDW-1:0]   grant_id,
  output logic             busy,
  output logic             timeout
);

  localparam int unsigned    HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [HCW-1:0]   hold_cnt, hold_d;
  logic [IDW-1:0]   last_ptr, last_d;
  logic [WIDTH-1:0] grant_d;
  logic [IDW-1:0]   grant_id_d;
  logic             busy_d;
  logic             timeout_d;

  logic [WIDTH-1:0] masked_c;
  logic [IDW-1:0]   win_m, win_r, win_id;
  logic             hold_limit;
  logic             release_c;
  logic             take_c;

  // Find-first-one above last_ptr, falling back to find-first-one of all requests.
  always_comb begin
    masked_c = '0;
    win_m    = '0;
    win_r    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      masked_c[i] = req[i] && (IDW'(i) > last_ptr);
    end
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (masked_c[i]) win_m = IDW'(i);
      if (req[i])      win_r = IDW'(i);
    end
    win_id = (|masked_c) ? win_m : win_r;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant;
    grant_id_d = grant_id;
    busy_d     = busy;
    timeout_d  = 1'b0;
    hold_d     = hold_cnt;
    last_d     = last_ptr;
    take_c     = 1'b0;
    hold_limit = (hold_cnt == HOLD_LAST);
    release_c  = done || ((req & grant) == '0) || hold_limit;

    unique case (state_q)
      IDLE: begin
        take_c = |req;
      end
      OWNED: begin
        if (release_c) begin
          // done wins over a coincident hold limit, so no timeout is flagged then
          timeout_d = hold_limit && !done;
          take_c    = |req;
          if (!(|req)) begin
            state_d    = IDLE;
            grant_d    = '0;
            grant_id_d = '0;
            busy_d     = 1'b0;
            hold_d     = '0;
          end
        end else begin
          hold_d = hold_cnt + HCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (take_c) begin
      state_d    = OWNED;
      grant_d    = WIDTH'(1) << win_id;
      grant_id_d = win_id;
      busy_d     = 1'b1;
      hold_d     = '0;
      last_d     = win_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      last_ptr <= IDW'(WIDTH - 1);
    end else begin
      state_q  <= state_d;
      grant    <= grant_d;
      grant_id <= grant_id_d;
      busy     <= busy_d;
      timeout  <= timeout_d;
      hold_cnt <= hold_d;
      last_ptr <= last_d;
    end
  end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed and randomized checks of rr_grant_scheduler with WIDTH=4, MAX_HOLD=8.
module tb_rr_grant_scheduler;

  localparam int unsigned WIDTH    = 4;
  localparam int unsigned MAX_HOLD = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] req;
  logic             done;
  logic [WIDTH-1:0] grant;
  logic [1:0]       grant_id;
  logic             busy;
  logic             timeout;

  int vectors     = 0;
  int miscompares = 0;

  rr_grant_scheduler #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1ns after the edge and check the output invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("onehot0", 32'($onehot0(grant)), 32'(1));
    chk("busy_vs_grant", 32'(busy), 32'(|grant));
    if (busy) chk("grant_vs_id", 32'(grant), 32'(1) << grant_id);
  endtask

  task automatic expect_out(input string tag, input int g, input int id, input int b, input int t);
    chk($sformatf("%s.grant", tag),    32'(grant),    32'(g));
    chk($sformatf("%s.grant_id", tag), 32'(grant_id), 32'(id));
    chk($sformatf("%s.busy", tag),     32'(busy),     32'(b));
    chk($sformatf("%s.timeout", tag),  32'(timeout),  32'(t));
  endtask

  logic [WIDTH-1:0] req_p, grant_p;
  logic             done_p, busy_p, rel;
  int               hc, hc_p, maxw;
  int               waitc [WIDTH];

  initial begin
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;

    // Reset state
    tick();
    expect_out("reset", 0, 0, 0, 0);
    rst = 1'b0;

    // Full rotation with done one cycle after each grant
    req = 4'b1111;
    tick();
    expect_out("rot_first", 1, 0, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      done = 1'b0;
      tick();
      expect_out("rot_hold", 1 << ((k - 1) % 4), (k - 1) % 4, 1, 0);
      done = 1'b1;
      tick();
      expect_out("rot_next", 1 << (k % 4), k % 4, 1, 0);
    end

    // Sole requester, never done: 8-cycle hold, timeout, immediate regrant, restart
    done = 1'b0;
    req  = 4'b0100;
    tick();
    expect_out("sole_first", 4, 2, 1, 0);
    for (int k = 0; k < 7; k++) begin
      tick();
      expect_out("sole_hold", 4, 2, 1, 0);
    end
    tick();
    expect_out("sole_timeout", 4, 2, 1, 1);
    for (int k = 0; k < 7; k++) begin
      tick();
      expect_out("sole_hold2", 4, 2, 1, 0);
    end
    tick();
    expect_out("sole_timeout2", 4, 2, 1, 1);

    // Owner 1 with req=1011: rotation skips requester 0, then wraps to it
    req = 4'b0010;
    tick();
    expect_out("own1_grant", 2, 1, 1, 0);
    req = 4'b1011;
    tick();
    expect_out("own1_hold", 2, 1, 1, 0);
    done = 1'b1;
    tick();
    expect_out("skip0", 8, 3, 1, 0);
    done = 1'b0;
    tick();
    expect_out("own3_hold", 8, 3, 1, 0);
    done = 1'b1;
    tick();
    expect_out("wrap0", 1, 0, 1, 0);

    // Owner withdraws with nobody else requesting; done in IDLE is ignored
    done = 1'b0;
    req  = 4'b0010;
    tick();
    expect_out("wd_grant", 2, 1, 1, 0);
    tick();
    expect_out("wd_hold", 2, 1, 1, 0);
    req = 4'b0000;
    tick();
    expect_out("wd_idle", 0, 0, 0, 0);
    done = 1'b1;
    tick();
    expect_out("idle_done", 0, 0, 0, 0);
    done = 1'b0;

    // Reset mid-grant at hold_cnt=5, then last_ptr must be back at 3
    req = 4'b0100;
    tick();
    expect_out("pre_rst_grant", 4, 2, 1, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_out("pre_rst_hold", 4, 2, 1, 0);
    end
    rst = 1'b1;
    tick();
    expect_out("mid_rst", 0, 0, 0, 0);
    rst = 1'b0;
    req = 4'b1100;
    tick();
    expect_out("post_rst", 4, 2, 1, 0);

    // done coinciding with the hold limit: handover without a timeout pulse
    for (int k = 0; k < 7; k++) begin
      tick();
      expect_out("lim_hold", 4, 2, 1, 0);
    end
    done = 1'b1;
    tick();
    expect_out("done_at_limit", 8, 3, 1, 0);
    done = 1'b0;

    // Randomized traffic: stability while held, timeout timing, starvation bound
    rst = 1'b1;
    req = '0;
    tick();
    expect_out("rnd_reset", 0, 0, 0, 0);
    rst  = 1'b0;
    req  = 4'b1111;
    hc   = 0;
    maxw = 0;
    for (int i = 0; i < WIDTH; i++) waitc[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
      end
      done    = ($urandom_range(0, 7) == 0);
      req_p   = req;
      done_p  = done;
      grant_p = grant;
      busy_p  = busy;
      hc_p    = hc;
      tick();
      rel = busy_p && (done_p || ((req_p & grant_p) == '0) || (hc_p == int'(MAX_HOLD)));
      if (busy_p && !rel) begin
        chk("rnd_stable", 32'(grant), 32'(grant_p));
        hc = hc_p + 1;
      end else begin
        hc = busy ? 1 : 0;
      end
      chk("rnd_timeout", 32'(timeout), 32'(busy_p && (hc_p == int'(MAX_HOLD)) && !done_p));
      for (int i = 0; i < WIDTH; i++) begin
        if (req_p[i] && !grant[i]) waitc[i]++;
        else waitc[i] = 0;
        if (waitc[i] > maxw) maxw = waitc[i];
      end
    end
    chk("starve_max_le_25", 32'(maxw <= 25), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
